// File: rtl/pocket_stream_pkg.sv
// Shared types and helpers for the pocket stream blocks (FIFO read-side packers).
package pocket_stream_pkg;

  typedef enum logic {ACCUM, FLUSH} packer_state_t;

  // Width needed to count 0..ratio lanes inclusive.
  function automatic int lane_count_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Packs narrow FIFO read words into ratio-lane wide words on a valid/ready
// output; flush emits a partial word with its lane count.
module fifo_word_packer
  import pocket_stream_pkg::*;
#(
  parameter int in_width = 8,
  parameter int ratio    = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [in_width-1:0]                 in_data,
  input  logic                                in_valid,
  output logic                                in_ack,
  input  logic                                flush,
  output logic                                flush_done,
  output logic [in_width*ratio-1:0]           out_data,
  output logic [lane_count_width(ratio)-1:0]  out_words,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int OW = in_width * ratio;
  localparam int CW = $clog2(ratio);
  localparam int WW = lane_count_width(ratio);
  localparam logic [CW-1:0] LAST = CW'(ratio - 1);

  packer_state_t   state, state_nxt;
  logic [OW-1:0]   acc, acc_w, acc_nxt, ld_data;
  logic [CW-1:0]   lane_cnt, lane_nxt;
  logic [WW-1:0]   ld_words;
  logic            ld, fd_nxt, slot_free;

  assign slot_free = !out_valid || out_ready;

  // Accumulator with the incoming word merged into the current lane.
  always_comb begin
    acc_w = acc;
    acc_w[lane_cnt*in_width +: in_width] = in_data;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ACCUM;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    in_ack    = 1'b0;
    ld        = 1'b0;
    ld_data   = acc_w;
    ld_words  = WW'(ratio);
    acc_nxt   = acc;
    lane_nxt  = lane_cnt;
    fd_nxt    = 1'b0;
    case (state)
      ACCUM: begin
        // Only the last lane needs the output slot; earlier lanes never stall.
        in_ack = !(lane_cnt == LAST && !slot_free);
        if (in_valid && in_ack) begin
          if (lane_cnt == LAST) begin
            ld       = 1'b1;
            acc_nxt  = '0;
            lane_nxt = '0;
          end else begin
            acc_nxt  = acc_w;
            lane_nxt = lane_cnt + 1'b1;
          end
        end
        if (flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (lane_cnt == '0) begin
          fd_nxt    = 1'b1;
          state_nxt = ACCUM;
        end else if (slot_free) begin
          // Unused lanes are already zero since the accumulator clears on load.
          ld        = 1'b1;
          ld_data   = acc;
          ld_words  = WW'(lane_cnt);
          acc_nxt   = '0;
          lane_nxt  = '0;
          fd_nxt    = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc        <= '0;
      lane_cnt   <= '0;
      flush_done <= 1'b0;
      out_data   <= '0;
      out_words  <= '0;
      out_valid  <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      lane_cnt   <= lane_nxt;
      flush_done <= fd_nxt;
      if (ld) begin
        out_data  <= ld_data;
        out_words <= ld_words;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer (in_width=8, ratio=4): vector table, corner
// sequences, then random traffic against a queue-based reference model.
module tb_fifo_word_packer;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid, in_ack, flush, flush_done, out_valid, out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_words;

  int n_cmp = 0;
  int n_err = 0;

  fifo_word_packer #(.in_width(8), .ratio(R)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ack(in_ack), .flush(flush), .flush_done(flush_done),
    .out_data(out_data), .out_words(out_words), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; logic [7:0] d; bit f; bit r;
    bit ack; bit ov; logic [31:0] od; logic [2:0] ow; bit fd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge, then settle before sampling.
  task automatic drive(input bit v, input logic [7:0] d, input bit f, input bit r);
    @(posedge clk);
    #1;
    in_valid = v; in_data = d; flush = f; out_ready = r;
    #1;
  endtask

  task automatic chk_out(input string tag, input bit eack, input bit eov,
                         input logic [31:0] eod, input logic [2:0] eow, input bit efd);
    chk({tag, ".in_ack"}, in_ack, eack);
    chk({tag, ".out_valid"}, out_valid, eov);
    chk({tag, ".flush_done"}, flush_done, efd);
    if (eov) begin
      chk({tag, ".out_data"}, out_data, eod);
      chk({tag, ".out_words"}, out_words, eow);
    end
  endtask

  // Reference model state: pending lanes and the held output word.
  logic [7:0]  pend[$];
  bit          m_flush, m_ov, m_fd;
  logic [31:0] m_od;
  logic [2:0]  m_ow;

  function automatic logic [31:0] pack_q(input logic [7:0] q[$]);
    logic [31:0] w = '0;
    foreach (q[i]) w = w | (32'(q[i]) << (8 * i));
    return w;
  endfunction

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.out_words", out_words, 0);
    chk("rst.flush_done", flush_done, 0);
    #10 reset_n = 1'b1;
    #1 chk("rst.in_ack", in_ack, 1);

    // Full word, partial flush, empty flush, flush coinciding with 3rd accept.
    tbl.push_back('{1, 8'h11, 0, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{1, 8'h22, 0, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{1, 8'h33, 0, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{1, 8'h44, 0, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 1, 32'h44332211, 3'd4, 0});
    tbl.push_back('{1, 8'hAA, 0, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{1, 8'hBB, 0, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{0, 8'h00, 1, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{1, 8'hEE, 0, 1, 0, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{0, 8'h00, 0, 0, 1, 1, 32'h0000BBAA, 3'd2, 1});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 1, 32'h0000BBAA, 3'd2, 0});
    tbl.push_back('{0, 8'h00, 1, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 0, 32'h0, 3'd0, 1});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{1, 8'hA1, 0, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{1, 8'hB2, 0, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{1, 8'hCC, 1, 1, 1, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 0, 0, 32'h0, 3'd0, 0});
    tbl.push_back('{0, 8'h00, 0, 0, 1, 1, 32'h00CCB2A1, 3'd3, 1});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 1, 32'h00CCB2A1, 3'd3, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 1, 0, 32'h0, 3'd0, 0});
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      chk_out($sformatf("tbl%0d", i), tbl[i].ack, tbl[i].ov, tbl[i].od, tbl[i].ow, tbl[i].fd);
    end

    // Sustained stream: no bubbles, a packed word every 4 cycles.
    for (int i = 0; i < 20; i++) begin
      drive(i < 16, 8'(i), 0, 1);
      if (i < 16) chk($sformatf("strm%0d.in_ack", i), in_ack, 1);
      if (i >= 4 && i % 4 == 0 && i <= 16) begin
        chk($sformatf("strm%0d.out_valid", i), out_valid, 1);
        chk($sformatf("strm%0d.out_data", i), out_data,
            {8'(i - 1), 8'(i - 2), 8'(i - 3), 8'(i - 4)});
      end else begin
        chk($sformatf("strm%0d.out_valid", i), out_valid, 0);
      end
    end

    // Backpressure: 7 accepts then stall; one ready cycle takes the 8th word.
    for (int c = 0; c < 9; c++) begin
      drive(1, 8'h50 + 8'(c < 7 ? c : 7), 0, 0);
      chk($sformatf("bp%0d.in_ack", c), in_ack, c < 7);
      chk($sformatf("bp%0d.out_valid", c), out_valid, c >= 4);
      if (c >= 4) chk($sformatf("bp%0d.out_data", c), out_data, 32'h53525150);
    end
    drive(1, 8'h57, 0, 1);
    chk_out("bp9", 1, 1, 32'h53525150, 3'd4, 0);
    drive(0, 8'h00, 0, 0);
    chk_out("bp10", 1, 1, 32'h57565554, 3'd4, 0);
    drive(0, 8'h00, 0, 1);
    chk_out("bp11", 1, 1, 32'h57565554, 3'd4, 0);
    drive(0, 8'h00, 0, 1);
    chk_out("bp12", 1, 0, 32'h0, 3'd0, 0);

    // Reset mid-operation: word held and 3 lanes filled.
    for (int c = 0; c < 7; c++) drive(1, 8'h60 + 8'(c), 0, 0);
    drive(0, 8'h00, 0, 0);
    chk_out("prerst", 0, 1, 32'h63626160, 3'd4, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.out_data", out_data, 0);
    chk("midrst.out_words", out_words, 0);
    #2 reset_n = 1'b1;
    for (int c = 0; c < 4; c++) drive(1, 8'h71 + 8'(c), 0, 1);
    drive(0, 8'h00, 0, 1);
    chk_out("postrst", 1, 1, 32'h74737271, 3'd4, 0);
    drive(0, 8'h00, 0, 1);
    chk_out("postrst.drain", 1, 0, 32'h0, 3'd0, 0);

    // Random traffic against the reference model.
    pend.delete();
    m_flush = 0; m_ov = 0; m_fd = 0; m_od = '0; m_ow = '0;
    for (int c = 0; c < 400; c++) begin
      bit v, f, r, eack, slot_free, ld;
      logic [7:0] d;
      v = $urandom_range(0, 3) != 0;
      f = $urandom_range(0, 15) == 0;
      r = $urandom_range(0, 2) != 0;
      d = 8'($urandom);
      drive(v, d, f, r);
      eack = !m_flush && !(pend.size() == R - 1 && m_ov && !r);
      chk_out($sformatf("rnd%0d", c), eack, m_ov, m_od, m_ow, m_fd);
      slot_free = !m_ov || r;
      ld = 0;
      m_fd = 0;
      if (!m_flush) begin
        if (v && eack) begin
          pend.push_back(d);
          if (pend.size() == R) begin
            ld = 1; m_od = pack_q(pend); m_ow = 3'(R); pend.delete();
          end
        end
        if (f) m_flush = 1;
      end else if (pend.size() == 0) begin
        m_fd = 1; m_flush = 0;
      end else if (slot_free) begin
        ld = 1; m_od = pack_q(pend); m_ow = 3'(pend.size()); pend.delete();
        m_fd = 1; m_flush = 0;
      end
      if (ld) m_ov = 1;
      else if (r) m_ov = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
